// File: rtl/memory_stage_if.sv
// memory_stage_if
//  Data-memory request/acknowledge bus between the memory stage and data memory.
//  Signals:
//   req      request, held high until ack
//   wr       1 = store, 0 = load
//   addr     word-aligned byte address
//   wdata    lane-replicated store data
//   byte_en  active byte lanes of the access
//   ack      memory done; rdata valid in the same cycle
//   rdata    load word
//  Modports: master (memory stage side), slave (memory side).
interface memory_stage_if #(
  parameter int DWIDTH = 32
);
  logic              req;
  logic              wr;
  logic [DWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [3:0]        byte_en;
  logic              ack;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output req, wr, addr, wdata, byte_en,
    input  ack, rdata
  );

  modport slave (
    input  req, wr, addr, wdata, byte_en,
    output ack, rdata
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage
//  Pipeline stage in front of writeback. Non-memory instructions pass through
//  with one cycle of latency; aligned LOAD/STORE instructions run a req/ack
//  access on the data-memory bus before their result is handed to writeback.
//  Misaligned accesses never reach the bus and are flagged on the way out.
//  Ports:
//   mem_clk, mem_rst             clock, synchronous active-low reset
//   mem_i_*                      instruction from the previous stage, stall/flush
//   mem_bus                      data-memory bus (master side)
//   mem_o_funct..mem_o_ce        instruction fields registered for writeback
//   mem_o_data_load              load word shifted down to bit 0
//   mem_o_misaligned             output instruction had a misaligned address
//   mem_o_stall                  stall request to upstream stages
//   mem_o_flush                  mem_i_flush delayed by one cycle
module memory_stage #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 5,
  parameter int PC_WIDTH     = 32,
  parameter int FUNCT_WIDTH  = 3,
  parameter int OPCODE_WIDTH = 7,
  parameter logic [OPCODE_WIDTH-1:0] LOAD  = 7'b0000011,
  parameter logic [OPCODE_WIDTH-1:0] STORE = 7'b0100011
) (
  input  logic                    mem_clk,
  input  logic                    mem_rst,
  input  logic [FUNCT_WIDTH-1:0]  mem_i_funct,
  input  logic [OPCODE_WIDTH-1:0] mem_i_opcode,
  input  logic [DWIDTH-1:0]       mem_i_alu_result,
  input  logic [DWIDTH-1:0]       mem_i_rs2_data,
  input  logic                    mem_i_we_rd,
  input  logic [AWIDTH-1:0]       mem_i_rd_addr,
  input  logic [PC_WIDTH-1:0]     mem_i_pc,
  input  logic                    mem_i_ce,
  input  logic                    mem_i_stall,
  input  logic                    mem_i_flush,
  memory_stage_if.master          mem_bus,
  output logic [FUNCT_WIDTH-1:0]  mem_o_funct,
  output logic [OPCODE_WIDTH-1:0] mem_o_opcode,
  output logic                    mem_o_we_rd,
  output logic [AWIDTH-1:0]       mem_o_rd_addr,
  output logic [DWIDTH-1:0]       mem_o_rd_data,
  output logic [PC_WIDTH-1:0]     mem_o_pc,
  output logic                    mem_o_ce,
  output logic [DWIDTH-1:0]       mem_o_data_load,
  output logic                    mem_o_misaligned,
  output logic                    mem_o_stall,
  output logic                    mem_o_flush
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e state_q;

  // bus registers
  logic              req_q;
  logic              wr_q;
  logic [DWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [3:0]        byte_en_q;

  // instruction held while the access is outstanding
  logic [FUNCT_WIDTH-1:0]  funct_l_q;
  logic [OPCODE_WIDTH-1:0] opcode_l_q;
  logic                    we_rd_l_q;
  logic [AWIDTH-1:0]       rd_addr_l_q;
  logic [DWIDTH-1:0]       alu_l_q;
  logic [PC_WIDTH-1:0]     pc_l_q;
  logic [1:0]              offset_q;
  logic [DWIDTH-1:0]       rdata_buf_q;
  logic                    killed_q;

  // writeback-facing registers
  logic [FUNCT_WIDTH-1:0]  funct_q;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic                    we_rd_q;
  logic [AWIDTH-1:0]       rd_addr_q;
  logic [DWIDTH-1:0]       rd_data_q;
  logic [PC_WIDTH-1:0]     pc_q;
  logic                    ce_q;
  logic [DWIDTH-1:0]       data_load_q;
  logic                    misaligned_q;
  logic                    flush_q;

  // decode of the incoming instruction
  logic              is_load;
  logic              is_store;
  logic              is_mem;
  logic              is_half;
  logic              is_word;
  logic              misaligned_d;
  logic [3:0]        byte_en_d;
  logic [DWIDTH-1:0] wdata_d;
  logic [DWIDTH-1:0] load_src_d;
  logic [DWIDTH-1:0] load_shifted_d;
  logic              commit_d;

  assign is_load  = (mem_i_opcode == LOAD);
  assign is_store = (mem_i_opcode == STORE);
  assign is_mem   = is_load | is_store;
  // funct3[1:0]: 00 byte, 01 half, 1x word
  assign is_half  = (mem_i_funct[1:0] == 2'b01);
  assign is_word  = mem_i_funct[1];
  assign misaligned_d = (is_half & mem_i_alu_result[0]) |
                        (is_word & (mem_i_alu_result[1:0] != 2'b00));

  // Lane selection and store-data replication so every lane carries the datum.
  always_comb begin
    byte_en_d = 4'b0000;
    wdata_d   = '0;
    if (is_word) begin
      byte_en_d = 4'b1111;
      wdata_d   = mem_i_rs2_data;
    end else if (is_half) begin
      byte_en_d = mem_i_alu_result[1] ? 4'b1100 : 4'b0011;
      wdata_d   = {2{mem_i_rs2_data[15:0]}};
    end else begin
      byte_en_d = 4'b0001 << mem_i_alu_result[1:0];
      wdata_d   = {4{mem_i_rs2_data[7:0]}};
    end
  end

  // In DONE the word comes from the buffer, otherwise straight off the bus.
  assign load_src_d     = (state_q == DONE) ? rdata_buf_q : mem_bus.rdata;
  assign load_shifted_d = load_src_d >> {offset_q, 3'b000};

  // A pending access hands its result to writeback this edge.
  assign commit_d = ((state_q == BUSY) & mem_bus.ack & ~mem_i_stall & ~killed_q & ~mem_i_flush) |
                    ((state_q == DONE) & ~mem_i_stall & ~mem_i_flush);

  // Main FSM and all registered outputs. The commit block at the end overrides
  // the per-state ce_q update when an access result is delivered.
  always_ff @(posedge mem_clk) begin
    if (!mem_rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_en_q    <= '0;
      funct_l_q    <= '0;
      opcode_l_q   <= '0;
      we_rd_l_q    <= 1'b0;
      rd_addr_l_q  <= '0;
      alu_l_q      <= '0;
      pc_l_q       <= '0;
      offset_q     <= '0;
      rdata_buf_q  <= '0;
      killed_q     <= 1'b0;
      funct_q      <= '0;
      opcode_q     <= '0;
      we_rd_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      pc_q         <= '0;
      ce_q         <= 1'b0;
      data_load_q  <= '0;
      misaligned_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      flush_q <= mem_i_flush;
      case (state_q)
        IDLE: begin
          if (mem_i_flush) begin
            ce_q <= 1'b0;
          end else if (!mem_i_stall) begin
            if (mem_i_ce && is_mem && !misaligned_d) begin
              funct_l_q   <= mem_i_funct;
              opcode_l_q  <= mem_i_opcode;
              we_rd_l_q   <= mem_i_we_rd & is_load;
              rd_addr_l_q <= mem_i_rd_addr;
              alu_l_q     <= mem_i_alu_result;
              pc_l_q      <= mem_i_pc;
              offset_q    <= mem_i_alu_result[1:0];
              killed_q    <= 1'b0;
              req_q       <= 1'b1;
              wr_q        <= is_store;
              addr_q      <= {mem_i_alu_result[DWIDTH-1:2], 2'b00};
              wdata_q     <= wdata_d;
              byte_en_q   <= byte_en_d;
              ce_q        <= 1'b0;
              state_q     <= BUSY;
            end else if (mem_i_ce) begin
              // Non-memory op, or a misaligned access that never reaches the bus.
              funct_q      <= mem_i_funct;
              opcode_q     <= mem_i_opcode;
              we_rd_q      <= mem_i_we_rd & ~is_mem;
              rd_addr_q    <= mem_i_rd_addr;
              rd_data_q    <= mem_i_alu_result;
              pc_q         <= mem_i_pc;
              data_load_q  <= '0;
              misaligned_q <= is_mem;
              ce_q         <= 1'b1;
            end else begin
              ce_q <= 1'b0;
            end
          end
        end
        BUSY: begin
          // A flush kills the result but the bus transfer still completes.
          if (mem_i_flush) begin
            killed_q <= 1'b1;
          end
          if (mem_i_flush || !mem_i_stall) begin
            ce_q <= 1'b0;
          end
          if (mem_bus.ack) begin
            req_q       <= 1'b0;
            rdata_buf_q <= mem_bus.rdata;
            if (mem_i_stall && !killed_q && !mem_i_flush) begin
              state_q <= DONE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DONE: begin
          if (mem_i_flush || !mem_i_stall) begin
            ce_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (commit_d) begin
        funct_q      <= funct_l_q;
        opcode_q     <= opcode_l_q;
        we_rd_q      <= we_rd_l_q;
        rd_addr_q    <= rd_addr_l_q;
        rd_data_q    <= alu_l_q;
        pc_q         <= pc_l_q;
        data_load_q  <= load_shifted_d;
        misaligned_q <= 1'b0;
        ce_q         <= 1'b1;
      end
    end
  end

  assign mem_bus.req     = req_q;
  assign mem_bus.wr      = wr_q;
  assign mem_bus.addr    = addr_q;
  assign mem_bus.wdata   = wdata_q;
  assign mem_bus.byte_en = byte_en_q;

  assign mem_o_funct      = funct_q;
  assign mem_o_opcode     = opcode_q;
  assign mem_o_we_rd      = we_rd_q;
  assign mem_o_rd_addr    = rd_addr_q;
  assign mem_o_rd_data    = rd_data_q;
  assign mem_o_pc         = pc_q;
  assign mem_o_ce         = ce_q;
  assign mem_o_data_load  = data_load_q;
  assign mem_o_misaligned = misaligned_q;
  assign mem_o_flush      = flush_q;
  assign mem_o_stall      = mem_i_stall | (state_q != IDLE);

endmodule
